// File: rtl/apb_master_arb_if.sv
// Requester command/response and APB bus signals of the two-port APB master/arbiter.
// The master modport is the arbiter's view; slave is the requesters' and APB slave's side.
interface apb_master_arb_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 8
);
  logic              req_valid_0;
  logic              req_valid_1;
  logic              req_write_0;
  logic              req_write_1;
  logic [AWIDTH-1:0] req_addr_0;
  logic [AWIDTH-1:0] req_addr_1;
  logic [DWIDTH-1:0] req_wdata_0;
  logic [DWIDTH-1:0] req_wdata_1;
  logic              req_ready_0;
  logic              req_ready_1;
  logic              resp_valid_0;
  logic              resp_valid_1;
  logic [DWIDTH-1:0] resp_rdata;
  logic              resp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid_0, req_valid_1, req_write_0, req_write_1,
    input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_rdata, resp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid_0, req_valid_1, req_write_0, req_write_1,
    output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_rdata, resp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-port round-robin APB master: one outstanding SETUP/ACCESS transfer at a time.
// Optional ACCESS wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_master_arb_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic              last_owner_q;
  logic              owner_q;
  logic              pwrite_q;
  logic [AWIDTH-1:0] paddr_q;
  logic [DWIDTH-1:0] pwdata_q;
  logic              resp_valid_0_q, resp_valid_1_q;
  logic [DWIDTH-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              grant_0, grant_1;
  logic              done, timeout;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master_arb: TIMEOUT must be in 1..255");
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else if (state_q == StSetup) begin
      wait_cnt_q <= '0;
    end else if (state_q == StAccess && !bus.PREADY) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // PREADY on the limit cycle still wins over the abort.
  assign timeout = (state_q == StAccess) && !bus.PREADY && (wait_cnt_q == 8'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Tie goes to whichever requester did not own the previous transfer.
        grant_0 = bus.req_valid_0 && (!bus.req_valid_1 || last_owner_q);
        grant_1 = bus.req_valid_1 && !grant_0;
        if (grant_0 || grant_1) state_d = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (bus.PREADY) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q        <= StIdle;
      last_owner_q   <= 1'b1;
      owner_q        <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      resp_valid_0_q <= 1'b0;
      resp_valid_1_q <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      resp_valid_0_q <= 1'b0;
      resp_valid_1_q <= 1'b0;
      if (grant_0 || grant_1) begin
        owner_q      <= grant_1;
        last_owner_q <= grant_1;
        pwrite_q     <= grant_1 ? bus.req_write_1 : bus.req_write_0;
        paddr_q      <= grant_1 ? bus.req_addr_1  : bus.req_addr_0;
        pwdata_q     <= grant_1 ? bus.req_wdata_1 : bus.req_wdata_0;
      end
      if (done || timeout) begin
        resp_valid_0_q <= !owner_q;
        resp_valid_1_q <= owner_q;
        resp_rdata_q   <= (done && !pwrite_q) ? bus.PRDATA : '0;
        resp_err_q     <= timeout || bus.PSLVERR;
      end
    end
  end

  // Gated by reset so nothing is accepted while the bus is held in reset.
  assign bus.req_ready_0  = grant_0 && PRESETn;
  assign bus.req_ready_1  = grant_1 && PRESETn;
  assign bus.resp_valid_0 = resp_valid_0_q;
  assign bus.resp_valid_1 = resp_valid_1_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.PSEL         = (state_q != StIdle);
  assign bus.PENABLE      = (state_q == StAccess);
  assign bus.PWRITE       = pwrite_q;
  assign bus.PADDR        = paddr_q;
  assign bus.PWDATA       = pwdata_q;

endmodule
